// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer with one-entry decode buffer; FETCH_CTRL_PERF_EN adds fetch/wait counters
module fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_addr,
  input  logic        i_redirect,
  input  logic        i_halt,
  input  logic        i_stall,
  output logic        o_pc_hold,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_wait_cnt,
`endif
  output logic        o_halted
);
  typedef enum logic [1:0] {REQ, WAIT, FULL, HALTED} state_t;
  state_t state;
  logic [31:0] req_addr, buf_inst, buf_pc;
  logic buf_valid, discard, halt_pend;
  logic halt_now, grant, load, buf_nxt;
  always_comb begin
    halt_now = halt_pend | i_halt;
    o_mem_req = i_rst_n && state == REQ && !i_redirect;
    grant = o_mem_req && i_mem_gnt;
    load = state == WAIT && i_mem_rvalid && !discard && !i_redirect;
    buf_nxt = !i_redirect && (load || (buf_valid && i_stall));
  end
  assign o_mem_addr = req_addr;
  assign o_pc_hold = !grant;
  assign o_inst_valid = buf_valid;
  assign o_inst = buf_inst;
  assign o_inst_pc = buf_pc;
  assign o_halted = state == HALTED;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= REQ;
      req_addr <= RESET_ADDR;
      buf_inst <= '0;
      buf_pc <= RESET_ADDR;
      buf_valid <= 1'b0;
      discard <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      halt_pend <= halt_now;
      buf_valid <= buf_nxt;
      if (load) {buf_inst, buf_pc} <= {i_mem_rdata, req_addr};
      case (state)
        REQ:
          if (grant) state <= WAIT;
          else if (halt_now) state <= HALTED;
          else if (i_redirect) req_addr <= i_pc_addr;
        WAIT:
          if (i_mem_rvalid) begin
            discard <= 1'b0;
            if (halt_now) state <= HALTED;
            else if (buf_nxt && i_stall) state <= FULL;
            else begin
              state <= REQ;
              req_addr <= i_pc_addr;
            end
          end else if (i_redirect) discard <= 1'b1;
        FULL:
          if (halt_now) state <= HALTED;
          else if (i_redirect || !i_stall) begin
            state <= REQ;
            req_addr <= i_pc_addr;
          end
        default: ;
      endcase
    end
  end
`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_fetch_cnt <= '0;
      o_wait_cnt <= '0;
    end else begin
      o_fetch_cnt <= o_fetch_cnt + 32'(buf_valid && !i_stall && !i_redirect);
      o_wait_cnt <= o_wait_cnt + 32'(state == WAIT);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for fetch_ctrl with a simple PC model
module tb_fetch_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_pc_addr;
  logic        i_redirect = 1'b0;
  logic        i_halt = 1'b0;
  logic        i_stall = 1'b0;
  logic        o_pc_hold;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_halted;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] o_fetch_cnt, o_wait_cnt;
`endif
  logic [31:0] pc, tgt = '0;
  int n_vec = 0, n_err = 0;

  fetch_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_addr(i_pc_addr), .i_redirect(i_redirect),
    .i_halt(i_halt), .i_stall(i_stall), .o_pc_hold(o_pc_hold), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_inst_valid(o_inst_valid), .o_inst(o_inst),
    .o_inst_pc(o_inst_pc),
`ifdef FETCH_CTRL_PERF_EN
    .o_fetch_cnt(o_fetch_cnt), .o_wait_cnt(o_wait_cnt),
`endif
    .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  // PC model: advances by 4 on each released hold, jumps to tgt on redirect
  assign i_pc_addr = i_redirect ? tgt : pc;
  always @(posedge i_clk)
    pc <= !i_rst_n ? 32'h0 : i_redirect ? tgt : !o_pc_hold ? pc + 32'd4 : pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    tick;
    tick;
    #1;
    chk("rst_req", 32'(o_mem_req), 0);
    chk("rst_hold", 32'(o_pc_hold), 1);
    chk("rst_valid", 32'(o_inst_valid), 0);
    chk("rst_addr", o_mem_addr, 32'h0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_ipc", o_inst_pc, 32'h0);
    chk("rst_halted", 32'(o_halted), 0);
    tick;
    i_rst_n = 1'b1;
    #1;
    chk("rel_req", 32'(o_mem_req), 1);
    chk("rel_hold", 32'(o_pc_hold), 1);
    // zero-wait fetch of 0x13 at address 0
    i_mem_gnt = 1'b1;
    #1;
    chk("t1_gnt_hold", 32'(o_pc_hold), 0);
    tick;
    i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h0000_0013;
    #1;
    chk("t1_wait_req", 32'(o_mem_req), 0);
    chk("t1_wait_valid", 32'(o_inst_valid), 0);
    tick;
    i_mem_rvalid = 1'b0;
    #1;
    chk("t1_valid", 32'(o_inst_valid), 1);
    chk("t1_inst", o_inst, 32'h13);
    chk("t1_ipc", o_inst_pc, 32'h0);
    chk("t1_req2", 32'(o_mem_req), 1);
    chk("t1_addr2", o_mem_addr, 32'h4);
    // grant withheld for three cycles
    for (int i = 0; i < 2; i++) begin
      tick;
      #1;
      chk("t2_addr", o_mem_addr, 32'h4);
      chk("t2_hold", 32'(o_pc_hold), 1);
      chk("t2_req", 32'(o_mem_req), 1);
    end
    tick;
    i_mem_gnt = 1'b1;
    #1;
    chk("t2_gnt_hold", 32'(o_pc_hold), 0);
    chk("t2_gnt_addr", o_mem_addr, 32'h4);
    tick;
    i_mem_gnt = 1'b0;
    #1;
    chk("t2_after_hold", 32'(o_pc_hold), 1);
    // redirect while waiting drops the response
    i_redirect = 1'b1;
    tgt = 32'h100;
    #1;
    chk("t3_req", 32'(o_mem_req), 0);
    tick;
    i_redirect = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'hdead_beef;
    #1;
    chk("t3_valid_a", 32'(o_inst_valid), 0);
    tick;
    i_mem_rvalid = 1'b0;
    #1;
    chk("t3_valid_b", 32'(o_inst_valid), 0);
    chk("t3_req", 32'(o_mem_req), 1);
    chk("t3_addr", o_mem_addr, 32'h100);
    // stall with a full buffer
    i_mem_gnt = 1'b1;
    tick;
    i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h00a0_0093;
    i_stall = 1'b1;
    tick;
    i_mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_req", 32'(o_mem_req), 0);
      chk("t4_valid", 32'(o_inst_valid), 1);
      chk("t4_inst", o_inst, 32'h00a0_0093);
      chk("t4_ipc", o_inst_pc, 32'h100);
      tick;
    end
    i_stall = 1'b0;
    #1;
    chk("t4_drop_req", 32'(o_mem_req), 0);
    chk("t4_drop_valid", 32'(o_inst_valid), 1);
    tick;
    #1;
    chk("t4_next_req", 32'(o_mem_req), 1);
    chk("t4_next_addr", o_mem_addr, 32'h104);
    chk("t4_next_valid", 32'(o_inst_valid), 0);
    // halt while waiting
    i_mem_gnt = 1'b1;
    tick;
    i_mem_gnt = 1'b0;
    i_halt = 1'b1;
    #1;
    chk("t5_wait_halted", 32'(o_halted), 0);
    tick;
    i_halt = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h1234_5678;
    #1;
    chk("t5_rv_halted", 32'(o_halted), 0);
    tick;
    i_mem_rvalid = 1'b0;
    #1;
    chk("t5_valid", 32'(o_inst_valid), 1);
    chk("t5_inst", o_inst, 32'h1234_5678);
    chk("t5_ipc", o_inst_pc, 32'h104);
    chk("t5_halted", 32'(o_halted), 1);
    chk("t5_req", 32'(o_mem_req), 0);
    chk("t5_hold", 32'(o_pc_hold), 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      #1;
      chk("t5_park_valid", 32'(o_inst_valid), 0);
      chk("t5_park_req", 32'(o_mem_req), 0);
      chk("t5_park_halted", 32'(o_halted), 1);
    end
    i_rst_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(o_mem_req), 0);
    tick;
    #1;
    chk("t5_rst_halted", 32'(o_halted), 0);
    // reset during WAIT, then a late response
    i_rst_n = 1'b1;
    i_mem_gnt = 1'b1;
    tick;
    i_mem_gnt = 1'b0;
    i_rst_n = 1'b0;
    tick;
    i_rst_n = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'hbad0_bad0;
    #1;
    chk("t6_req", 32'(o_mem_req), 1);
    chk("t6_addr", o_mem_addr, 32'h0);
    tick;
    i_mem_rvalid = 1'b0;
    #1;
    chk("t6_valid", 32'(o_inst_valid), 0);
    chk("t6_req_b", 32'(o_mem_req), 1);
`ifdef FETCH_CTRL_PERF_EN
    i_rst_n = 1'b0;
    tick;
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_mem_gnt = 1'b1;
      tick;
      i_mem_gnt = 1'b0;
      tick;
      i_mem_rvalid = 1'b1;
      i_mem_rdata = 32'h13;
      tick;
      i_mem_rvalid = 1'b0;
    end
    tick;
    #1;
    chk("perf_fetch", o_fetch_cnt, 32'd3);
    chk("perf_wait", o_wait_cnt, 32'd6);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
